// File: rtl/ptp_pps_gen.sv
// ptp_pps_gen
//   Consumer of the RTC time {sec[79:32], ns[31:0]}. Produces a PPS pulse
//   aligned to each seconds rollover (programmable, clamped width) and a
//   one-shot target-time trigger with arm / fire / missed / cancel.
//
//   Optional feature macro: PTP_PPS_TRIG_TS_EN
//     defined     -> trig_ts_o captures rtc_std_i on the fire edge
//     not defined -> trig_ts_o tied to zero, no capture register
//
//   Single clock domain (rtc_clk), synchronous active-high reset (rtc_rst).

module ptp_pps_gen #(
  parameter logic [31:0] PPS_MAX_W = 32'd500_000_000,
  parameter logic [31:0] NS_MAX    = 32'd999_999_999
) (
  input  logic        rtc_clk,
  input  logic        rtc_rst,
  input  logic [79:0] rtc_std_i,
  input  logic        pps_en_i,
  input  logic [31:0] pps_width_i,
  input  logic [47:0] trig_sc_i,
  input  logic [31:0] trig_ns_i,
  input  logic        trig_arm_i,
  input  logic        trig_cancel_i,
  output logic        pps_o,
  output logic        trig_o,
  output logic        trig_armed_o,
  output logic        trig_missed_o,
  output logic [79:0] trig_ts_o
);

  typedef enum logic [0:0] {
    TRIG_IDLE  = 1'b0,
    TRIG_ARMED = 1'b1
  } trig_state_t;

  // ------------------------------------------------------------------
  // Time split
  // ------------------------------------------------------------------
  logic [47:0] sec_now;
  logic [31:0] ns_now;

  assign sec_now = rtc_std_i[79:32];
  assign ns_now  = rtc_std_i[31:0];

  // ------------------------------------------------------------------
  // Rollover detection
  // ------------------------------------------------------------------
  logic [47:0] sec_d1_reg;
  logic [47:0] sec_d1_inc;
  logic        roll;
  logic        sec_jump;

  // A rollover is exactly +1 second (modulo 2^48). Any other change of
  // the seconds field (offset step, clear, backward step) is a jump.
  assign sec_d1_inc = sec_d1_reg + 48'd1;
  assign roll       = (sec_now == sec_d1_inc);
  assign sec_jump   = (sec_now != sec_d1_reg) && !roll;

  // Delayed copy of the seconds field, reloaded every cycle.
  always_ff @(posedge rtc_clk) begin
    if (rtc_rst) begin
      sec_d1_reg <= 48'd0;
    end else begin
      sec_d1_reg <= sec_now;
    end
  end

  // ------------------------------------------------------------------
  // PPS generator
  // ------------------------------------------------------------------
  logic [31:0] pps_w;
  logic        pps_reg;
  logic        pps_next;

  // Width clamp: requests beyond PPS_MAX_W are limited to PPS_MAX_W.
  assign pps_w = (pps_width_i > PPS_MAX_W) ? PPS_MAX_W : pps_width_i;

  // Rise on an enabled rollover (also restarts the width while high);
  // otherwise stay high only while enabled, no jump, and ns below width.
  // With w = 0 the first sample after the rise already satisfies
  // ns >= w, so the pulse is exactly one cycle long.
  always_comb begin
    pps_next = 1'b0;
    if (roll && pps_en_i) begin
      pps_next = 1'b1;
    end else if (pps_reg) begin
      if (!pps_en_i) begin
        pps_next = 1'b0;
      end else if (sec_jump) begin
        pps_next = 1'b0;
      end else if (ns_now >= pps_w) begin
        pps_next = 1'b0;
      end else begin
        pps_next = 1'b1;
      end
    end
  end

  // PPS output register.
  always_ff @(posedge rtc_clk) begin
    if (rtc_rst) begin
      pps_reg <= 1'b0;
    end else begin
      pps_reg <= pps_next;
    end
  end

  assign pps_o = pps_reg;

  // ------------------------------------------------------------------
  // Trigger FSM
  // ------------------------------------------------------------------
  trig_state_t state_reg;
  trig_state_t state_next;
  logic [79:0] target_reg;
  logic [79:0] target_next;
  logic [79:0] arm_target;
  logic        arm_illegal;
  logic        arm_past;
  logic        fire_cond;
  logic        fire_next;
  logic        missed_next;
  logic        trig_reg;
  logic        missed_reg;

  assign arm_target  = {trig_sc_i, trig_ns_i};
  assign arm_illegal = (trig_ns_i > NS_MAX);
  // A target equal to the current time is already too late to fire.
  assign arm_past    = (arm_target <= rtc_std_i);
  assign fire_cond   = (state_reg == TRIG_ARMED) && (rtc_std_i >= target_reg);

  // Next-state logic. Cancel wins over everything. Otherwise a pending
  // fire is taken first, and a same-cycle arm is then evaluated against
  // the post-fire state. An illegal arm only reports missed and leaves an
  // existing armed target untouched.
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    fire_next   = 1'b0;
    missed_next = 1'b0;
    if (trig_cancel_i) begin
      state_next = TRIG_IDLE;
    end else begin
      if (fire_cond) begin
        fire_next  = 1'b1;
        state_next = TRIG_IDLE;
      end
      if (trig_arm_i) begin
        if (arm_illegal) begin
          missed_next = 1'b1;
        end else if (arm_past) begin
          missed_next = 1'b1;
          state_next  = TRIG_IDLE;
        end else begin
          target_next = arm_target;
          state_next  = TRIG_ARMED;
        end
      end
    end
  end

  // State, target and pulse registers.
  always_ff @(posedge rtc_clk) begin
    if (rtc_rst) begin
      state_reg  <= TRIG_IDLE;
      target_reg <= 80'd0;
      trig_reg   <= 1'b0;
      missed_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      trig_reg   <= fire_next;
      missed_reg <= missed_next;
    end
  end

  assign trig_o        = trig_reg;
  assign trig_missed_o = missed_reg;
  assign trig_armed_o  = (state_reg == TRIG_ARMED);

  // ------------------------------------------------------------------
  // Optional fire timestamp
  // ------------------------------------------------------------------
`ifdef PTP_PPS_TRIG_TS_EN
  logic [79:0] ts_reg;

  // Capture the time at which the fire condition was seen; hold it.
  always_ff @(posedge rtc_clk) begin
    if (rtc_rst) begin
      ts_reg <= 80'd0;
    end else if (fire_next) begin
      ts_reg <= rtc_std_i;
    end
  end

  assign trig_ts_o = ts_reg;
`else
  assign trig_ts_o = 80'h0;
`endif

endmodule

// File: tb/tb_ptp_pps_gen.sv
// Testbench for ptp_pps_gen: table-driven vectors, hand sequences for the
// multi-cycle cases, then randomized stimulus against a behavioural model.

module tb_ptp_pps_gen;

  logic        rtc_clk = 1'b0;
  logic        rtc_rst;
  logic [79:0] rtc_std;
  logic        pps_en;
  logic [31:0] pps_width;
  logic [47:0] trig_sc;
  logic [31:0] trig_ns;
  logic        trig_arm;
  logic        trig_cancel;
  logic        pps_o;
  logic        trig_o;
  logic        trig_armed_o;
  logic        trig_missed_o;
  logic [79:0] trig_ts_o;

  int n_pass  = 0;
  int n_total = 0;

  ptp_pps_gen dut (
    .rtc_clk       (rtc_clk),
    .rtc_rst       (rtc_rst),
    .rtc_std_i     (rtc_std),
    .pps_en_i      (pps_en),
    .pps_width_i   (pps_width),
    .trig_sc_i     (trig_sc),
    .trig_ns_i     (trig_ns),
    .trig_arm_i    (trig_arm),
    .trig_cancel_i (trig_cancel),
    .pps_o         (pps_o),
    .trig_o        (trig_o),
    .trig_armed_o  (trig_armed_o),
    .trig_missed_o (trig_missed_o),
    .trig_ts_o     (trig_ts_o)
  );

  always #5 rtc_clk = ~rtc_clk;

  // ---------------- behavioural reference model ----------------
  logic [47:0] m_prev_sec;
  logic        m_pps, m_trig, m_missed, m_armed;
  logic [79:0] m_tgt, m_ts;

  task automatic model_reset();
    m_prev_sec = '0; m_pps = 0; m_trig = 0; m_missed = 0; m_armed = 0;
    m_tgt = '0; m_ts = '0;
  endtask

  task automatic model_step();
    logic [47:0] s;
    logic [47:0] s_exp;
    longint unsigned ns, wcap;
    bit rolled, other_change, fire;
    logic [79:0] tgt_in;
    s = rtc_std[79:32];
    ns = rtc_std[31:0];
    wcap = (pps_width > 32'd500_000_000) ? 64'd500_000_000 : 64'(pps_width);
    s_exp = m_prev_sec + 48'd1;
    rolled = (s == s_exp);
    other_change = (s != m_prev_sec) && !rolled;
    m_pps = (pps_en && rolled) || (m_pps && pps_en && !other_change && ns < wcap);
    m_prev_sec = s;

    tgt_in = {trig_sc, trig_ns};
    fire = m_armed && (rtc_std >= m_tgt) && !trig_cancel;
    m_trig = fire;
    m_missed = 0;
    if (fire) begin
      m_armed = 0;
`ifdef PTP_PPS_TRIG_TS_EN
      m_ts = rtc_std;
`endif
    end
    if (trig_cancel) m_armed = 0;
    else if (trig_arm) begin
      if (trig_ns > 32'd999_999_999) m_missed = 1;
      else if (tgt_in <= rtc_std) begin m_missed = 1; m_armed = 0; end
      else begin m_armed = 1; m_tgt = tgt_in; end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic step();
    if (rtc_rst) model_reset(); else model_step();
    @(posedge rtc_clk);
    #1;
    trig_arm = 0;
    trig_cancel = 0;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_t(input longint unsigned s, input longint unsigned n);
    logic [63:0] sv, nv;
    sv = s; nv = n;
    rtc_std = {sv[47:0], nv[31:0]};
  endtask

  task automatic arm_at(input longint unsigned s, input longint unsigned n);
    logic [63:0] sv, nv;
    sv = s; nv = n;
    trig_sc = sv[47:0]; trig_ns = nv[31:0]; trig_arm = 1;
  endtask

  task automatic do_reset();
    rtc_rst = 1;
    step(); step();
    rtc_rst = 0;
  endtask

  // ---------------- table ----------------
  typedef struct {
    longint unsigned sec, ns;
    bit en;
    longint unsigned w;
    bit arm, cancel;
    longint unsigned tsc, tns;
    logic [3:0] exp;   // {pps, trig, missed, armed}
  } vec_t;

  function automatic vec_t mkv(longint unsigned sec, longint unsigned ns, bit en, longint unsigned w,
                               bit arm, bit cancel, longint unsigned tsc, longint unsigned tns,
                               logic [3:0] exp);
    vec_t v;
    v.sec = sec; v.ns = ns; v.en = en; v.w = w; v.arm = arm; v.cancel = cancel;
    v.tsc = tsc; v.tns = tns; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    longint unsigned cur_sec, cur_ns;
    bit found;
    int hi_cnt;
    logic [31:0] wv;

    tbl[0]  = mkv(5, 999_999_992, 1, 16,            0, 0, 0, 0,             4'b0000);
    tbl[1]  = mkv(6, 0,           1, 16,            0, 0, 0, 0,             4'b1000);
    tbl[2]  = mkv(6, 8,           1, 16,            0, 0, 0, 0,             4'b1000);
    tbl[3]  = mkv(6, 16,          1, 16,            0, 0, 0, 0,             4'b0000);
    tbl[4]  = mkv(6, 24,          1, 16,            1, 0, 6, 40,            4'b0001);
    tbl[5]  = mkv(6, 32,          1, 16,            0, 0, 0, 0,             4'b0001);
    tbl[6]  = mkv(6, 40,          1, 16,            0, 0, 0, 0,             4'b0100);
    tbl[7]  = mkv(6, 48,          1, 16,            1, 0, 6, 40,            4'b0010);
    tbl[8]  = mkv(7, 0,           1, 0,             1, 0, 7, 1_000_000_000, 4'b1010);
    tbl[9]  = mkv(7, 8,           1, 0,             1, 0, 7, 100,           4'b0001);
    tbl[10] = mkv(7, 16,          1, 0,             1, 1, 7, 200,           4'b0000);
    tbl[11] = mkv(8, 0,           0, 0,             1, 0, 8, 8,             4'b0001);
    tbl[12] = mkv(8, 8,           0, 0,             1, 0, 9, 0,             4'b0101);
    tbl[13] = mkv(8, 16,          1, 2_000_000_000, 0, 0, 0, 0,             4'b0001);
    tbl[14] = mkv(9, 0,           1, 2_000_000_000, 0, 0, 0, 0,             4'b1100);
    tbl[15] = mkv(9, 8,           1, 2_000_000_000, 0, 0, 0, 0,             4'b1000);
    tbl[16] = mkv(3, 0,           1, 2_000_000_000, 0, 0, 0, 0,             4'b0000);

    rtc_rst = 1; rtc_std = '0; pps_en = 0; pps_width = 0;
    trig_sc = '0; trig_ns = '0; trig_arm = 0; trig_cancel = 0;
    model_reset();
    do_reset();
    check("reset_outputs", {pps_o, trig_o, trig_missed_o, trig_armed_o, trig_ts_o}, 84'h0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 17; i++) begin
      set_t(tbl[i].sec, tbl[i].ns);
      pps_en = tbl[i].en;
      wv = 32'(tbl[i].w);
      pps_width = wv;
      if (tbl[i].arm) arm_at(tbl[i].tsc, tbl[i].tns);
      trig_cancel = tbl[i].cancel;
      step();
      $display("vec %0d: {%0d,%0d} out=%b exp=%b", i, tbl[i].sec, tbl[i].ns,
               {pps_o, trig_o, trig_missed_o, trig_armed_o}, tbl[i].exp);
      check($sformatf("vec%0d", i), {pps_o, trig_o, trig_missed_o, trig_armed_o}, tbl[i].exp);
    end

    // ---- test 1: rollover, width 100, tick 8 ----
    do_reset();
    pps_en = 1; pps_width = 100;
    set_t(5, 999_999_992); step();
    check("t1_pre", pps_o, 0);
    set_t(6, 0); step();
    check("t1_rise", pps_o, 1);
    for (longint unsigned n = 8; n <= 104; n += 8) begin
      set_t(6, n); step();
      check($sformatf("t1_ns%0d", n), pps_o, (n < 100) ? 1 : 0);
    end

    // ---- test 2: width 0, three rollovers ----
    pps_width = 0;
    hi_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      set_t(7 + k, 0); step();
      if (pps_o) hi_cnt++;
      check($sformatf("t2_roll%0d", k), pps_o, 1);
      set_t(7 + k, 8); step();
      check($sformatf("t2_fall%0d", k), pps_o, 0);
    end
    $display("t2: pulses=%0d", hi_cnt);

    // ---- test 3: width 2e9 clamps to 5e8 ----
    pps_width = 32'd2_000_000_000;
    set_t(10, 0); step();           check("t3_rise", pps_o, 1);
    set_t(10, 499_999_992); step(); check("t3_hold", pps_o, 1);
    set_t(10, 500_000_000); step(); check("t3_fall", pps_o, 0);

    // ---- test 4: jumps and clear ----
    pps_width = 100;
    set_t(11, 0); step(); check("t4_roll", pps_o, 1);
    set_t(13, 0); step(); check("t4_jump_high", pps_o, 0);
    set_t(14, 0); step(); check("t4_roll2", pps_o, 1);
    set_t(0, 0);  step(); check("t4_clear_high", pps_o, 0);
    set_t(2, 0);  step(); check("t4_jump_low", pps_o, 0);

    // ---- test 5: arm {20,500} from {20,0} ----
    do_reset();
    pps_en = 0;
    set_t(20, 0); arm_at(20, 500); step();
    check("t5_armed", {trig_armed_o, trig_o}, 2'b10);
    cur_ns = 0; found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      cur_ns += 8;
      set_t(20, cur_ns); step();
      if (trig_o) found = 1;
    end
    $display("t5: fire seen=%0d at ns=%0d", found, cur_ns);
    check("t5_fire_ns", {found, cur_ns[31:0]}, {1'b1, 32'd504});
    check("t5_disarm", trig_armed_o, 0);
`ifdef PTP_PPS_TRIG_TS_EN
    check("t5_ts", trig_ts_o, {48'd20, 32'd504});
`else
    check("t5_ts", trig_ts_o, 80'h0);
`endif
    set_t(20, cur_ns + 8); step();
    check("t5_one_cycle", trig_o, 0);

    // ---- test 6: missed, illegal, cancel, reset ----
    set_t(4, 0); arm_at(3, 0); step();
    check("t6_past", {trig_o, trig_missed_o, trig_armed_o}, 3'b010);
    set_t(4, 8); step();
    check("t6_missed_1cyc", trig_missed_o, 0);
    set_t(4, 16); arm_at(5, 1_000_000_000); step();
    check("t6_illegal", {trig_o, trig_missed_o, trig_armed_o}, 3'b010);
    set_t(4, 24); arm_at(30, 0); step();
    check("t6_armed30", trig_armed_o, 1);
    set_t(4, 32); trig_cancel = 1; step();
    check("t6_cancel", {trig_o, trig_armed_o}, 2'b00);
    set_t(30, 0); step();
    set_t(30, 8); step();
    check("t6_no_fire", {trig_o, trig_armed_o}, 2'b00);
    pps_en = 1; pps_width = 100;
    set_t(31, 0); arm_at(40, 0); step();
    check("t6_pre_reset", {pps_o, trig_armed_o}, 2'b11);
    rtc_rst = 1; step(); rtc_rst = 0;
    check("t6_reset", {pps_o, trig_o, trig_missed_o, trig_armed_o, trig_ts_o}, 84'h0);

    // ---- randomized against model ----
    do_reset();
    cur_sec = 100; cur_ns = 0; pps_en = 1; pps_width = 300_000_000;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) cur_sec += $urandom_range(2, 5);
      else if (r < 4) begin cur_sec = 0; cur_ns = $urandom_range(0, 999_999_999); end
      else if (r < 6 && cur_sec > 0) cur_sec -= 1;
      else begin
        cur_ns += $urandom_range(0, 150_000_000);
        if (cur_ns > 999_999_999) begin cur_ns -= 1_000_000_000; cur_sec += 1; end
      end
      set_t(cur_sec, cur_ns);
      if (i % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: pps_width = 0;
          1: pps_width = $urandom_range(1, 600_000_000);
          default: pps_width = 32'd2_000_000_000;
        endcase
      end
      if ($urandom_range(0, 49) == 0) pps_en = ~pps_en;
      if ($urandom_range(0, 5) == 0) begin
        longint unsigned ts, tn;
        ts = ($urandom_range(0, 3) == 0 && cur_sec > 0) ? cur_sec - 1 : cur_sec + $urandom_range(0, 1);
        tn = ($urandom_range(0, 7) == 0) ? 64'd1_000_000_000 + $urandom_range(0, 1000)
                                         : longint'($urandom_range(0, 999_999_999));
        arm_at(ts, tn);
      end
      if ($urandom_range(0, 39) == 0) trig_cancel = 1;
      step();
      check($sformatf("rand%0d", i),
            {pps_o, trig_o, trig_missed_o, trig_armed_o, trig_ts_o},
            {m_pps, m_trig, m_missed, m_armed, m_ts});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
